pwm_duty_sequencer: RTL and testbench

Duty-cycle controller for the 8-bit PWM generator. It accepts a target duty over a valid/ready handshake and ramps the PWM `data` input from its current value to that target in fixed steps. Each step is applied only at a PWM period boundary, so the output never changes mid-period and shows no glitched pulse widths. It sits between the control logic and the PWM generator and shares that generator's clock and reset.

---
 rtl/pwm_pkg.sv | 24 ++
 rtl/pwm_period_counter.sv | 20 ++
 rtl/pwm_duty_sequencer.sv | 101 ++++++++++
 tb/tb_pwm_duty_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and step helper for the PWM-side blocks.
package pwm_pkg;

  localparam int              DUTY_W    = 8;
  localparam logic [DUTY_W-1:0] PHASE_MAX = 8'd255;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RAMP = 1'b1;

  // One step from cur toward tgt, clamped at tgt; 9-bit sums so nothing wraps.
  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt,
                                                    input logic [DUTY_W:0]   step);
    logic [DUTY_W:0] up;
    logic [DUTY_W:0] floor_lim;
    up        = {1'b0, cur} + step;
    floor_lim = {1'b0, tgt} + step;
    if (tgt > cur) begin
      return (up >= {1'b0, tgt}) ? tgt : up[DUTY_W-1:0];
    end
    return ({1'b0, cur} <= floor_lim) ? tgt : (cur - step[DUTY_W-1:0]);
  endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running 8-bit PWM phase counter with end-of-period tick decode.
module pwm_period_counter
  import pwm_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  logic [DUTY_W-1:0] phase_q, phase_d;

  assign phase_d = phase_q + 8'd1;
  assign tick_o  = (phase_q == PHASE_MAX);

  always_ff @(posedge clk_i) begin
    if (rst_i) phase_q <= '0;
    else       phase_q <= phase_d;
  end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Ramps the PWM duty toward an accepted target, one step per N periods,
// changing duty only on the last cycle of a PWM period.
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int STEP             = 1,
  parameter int PERIODS_PER_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] target,
  input  logic              target_valid,
  output logic              target_ready,
  input  logic              stop,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done,
  output logic              period_tick
);

  localparam logic [DUTY_W:0]   STEP9    = (DUTY_W+1)'(STEP);
  localparam logic [DUTY_W-1:0] DIV_LAST = DUTY_W'(PERIODS_PER_STEP - 1);

  logic [0:0]        state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] tgt_q, tgt_d;
  logic [DUTY_W-1:0] div_q, div_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DUTY_W-1:0] step_val;

  pwm_period_counter u_period (
    .clk_i  (clk),
    .rst_i  (rst),
    .tick_o (period_tick)
  );

  assign target_ready = (state_q == ST_IDLE) && !stop;
  assign step_val     = step_toward(duty_q, tgt_q, STEP9);

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    div_d   = div_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (stop) begin
      duty_d  = '0;
      state_d = ST_IDLE;
      div_d   = '0;
      busy_d  = 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (target_valid) begin
        tgt_d = target;
        div_d = '0;
        if (target == duty_q) begin
          done_d = 1'b1;
        end else begin
          state_d = ST_RAMP;
          busy_d  = 1'b1;
        end
      end
    end else if (period_tick) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        duty_d = step_val;
        if (step_val == tgt_q) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end else begin
        div_d = div_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      div_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      div_q   <= div_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign duty = duty_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Randomized scoreboard bench for pwm_duty_sequencer.
module tb_pwm_duty_sequencer;

  localparam int STEP = 60;
  localparam int PPS  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       target_valid = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] target = 8'd0;
  logic       target_ready, busy, done, period_tick;
  logic [7:0] duty;

  pwm_duty_sequencer #(.STEP(STEP), .PERIODS_PER_STEP(PPS)) dut (
    .clk          (clk),
    .rst          (rst),
    .target       (target),
    .target_valid (target_valid),
    .target_ready (target_ready),
    .stop         (stop),
    .duty         (duty),
    .busy         (busy),
    .done         (done),
    .period_tick  (period_tick)
  );

  always #5 clk = ~clk;

  typedef struct {bit is_done; int val; int cyc;} ev_t;
  ev_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit in_rst_q = 1'b0;
  int busy_lo = 0;
  int busy_hi = -1;
  int base_duty = 0;
  int last_t = 0;
  int plan_val[$];
  int plan_cyc[$];

  // cyc equals the DUT phase (mod 256) whenever reset has been low since it fell
  always @(posedge clk) begin
    cyc      <= rst ? 0 : cyc + 1;
    in_rst_q <= rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: protocol checks every cycle, scoreboard pops on duty change / done
  int   prev_duty = 0;
  bit   in_win;
  ev_t  e;
  always @(negedge clk) begin
    if (!(rst && !in_rst_q)) begin
      if (in_rst_q) begin
        chk("rst_duty", duty, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tick", period_tick, 0);
        if (!rst) chk("rst_ready", target_ready, 1);
        prev_duty = 0;
      end
      if (!rst) begin
        in_win = (cyc >= busy_lo) && (cyc <= busy_hi);
        chk("period_tick", period_tick, (cyc % 256 == 255));
        chk("busy", busy, in_win);
        chk("target_ready", target_ready, (!in_win && !stop));
        if (duty != prev_duty) begin
          if (sb.size() == 0) chk("unexpected_duty_change", duty, prev_duty);
          else begin
            e = sb.pop_front();
            chk("duty_event_kind", e.is_done, 0);
            chk("duty_value", duty, e.val);
            chk("duty_change_cycle", cyc, e.cyc);
          end
        end
        if (done) begin
          if (sb.size() == 0) chk("unexpected_done", done, 0);
          else begin
            e = sb.pop_front();
            chk("done_event_kind", e.is_done, 1);
            chk("done_cycle", cyc, e.cyc);
          end
        end
        prev_duty = duty;
      end
    end
  end

  function automatic int cur_duty(input int s);
    int d;
    d = base_duty;
    foreach (plan_cyc[i]) if (plan_cyc[i] <= s) d = plan_val[i];
    return d;
  endfunction

  // Reference: step k lands on the (PPS*k)-th period end after acceptance
  task automatic accept_plan(input int c, input int t);
    int d, v, t1, k, tl;
    d = cur_duty(c);
    base_duty = d;
    plan_val.delete();
    plan_cyc.delete();
    last_t = t;
    if (t == d) begin
      busy_lo = c + 1;
      busy_hi = c;
      sb.push_back('{is_done: 1'b1, val: t, cyc: c + 1});
    end else begin
      t1 = c + 1 + (255 - ((c + 1) % 256));
      v = d;
      k = 0;
      tl = t1;
      while (v != t) begin
        k++;
        if (t > v) v = (v + STEP > t) ? t : v + STEP;
        else       v = (v - STEP < t) ? t : v - STEP;
        tl = t1 + 256 * (PPS * k - 1);
        plan_val.push_back(v);
        plan_cyc.push_back(tl + 1);
        sb.push_back('{is_done: 1'b0, val: v, cyc: tl + 1});
      end
      busy_lo = c + 1;
      busy_hi = tl;
      sb.push_back('{is_done: 1'b1, val: t, cyc: tl + 1});
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 6000; n++) begin
      if (cyc > busy_hi) return;
      @(posedge clk); #1;
    end
    checks++; failures++;
    $display("FAIL wait_idle_timeout cyc=%0d actual=busy expected=idle", cyc);
  endtask

  task automatic send(input int t, input int early);
    if (!early) begin
      wait_idle();
      repeat ($urandom_range(0, 300)) @(posedge clk);
      #1;
    end
    target = 8'(t);
    target_valid = 1'b1;
    for (int n = 0; n < 6000; n++) begin
      if (cyc > busy_hi) begin
        accept_plan(cyc, t);
        @(posedge clk); #1;
        target_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    target_valid = 1'b0;
    checks++; failures++;
    $display("FAIL accept_timeout cyc=%0d actual=not_accepted expected=accepted", cyc);
  endtask

  task automatic do_stop(input int with_valid);
    int s, d;
    s = cyc;
    d = cur_duty(s);
    stop = 1'b1;
    if (with_valid) begin
      target = 8'($urandom_range(1, 255));
      target_valid = 1'b1;
    end
    while (sb.size() > 0 && sb[sb.size()-1].cyc > s) sb.delete(sb.size() - 1);
    if (busy_hi > s) busy_hi = s;
    base_duty = 0;
    last_t = 0;
    plan_val.delete();
    plan_cyc.delete();
    if (d != 0) sb.push_back('{is_done: 1'b0, val: 0, cyc: s + 1});
    @(posedge clk); #1;
    stop = 1'b0;
    target_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    sb.delete();
    plan_val.delete();
    plan_cyc.delete();
    base_duty = 0;
    last_t = 0;
    busy_lo = 0;
    busy_hi = -1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int t;
    do_reset(5);
    send(255, 0);        // clamp at top
    send(0, 1);          // clamp at bottom, held valid through previous ramp
    send(0, 1);          // equal target, accepted in the done cycle
    send(137, 1);
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 4))
        0:       t = 255;
        1:       t = 0;
        2:       t = last_t;
        default: t = $urandom_range(0, 255);
      endcase
      send(t, int'($urandom_range(0, 1)));
      if (i == 3) begin
        repeat ($urandom_range(1, 1200)) @(posedge clk);
        #1;
        do_stop(1);
      end
      if (i == 6) begin
        repeat ($urandom_range(1, 1500)) @(posedge clk);
        #1;
        do_reset(100);
      end
    end
    do_stop(0);
    send(40, 0);
    do_stop(1);
    wait_idle();
    repeat (10) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
